// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and parity helper for read_uart/write_uart
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
    localparam int UART_DATA_BITS = 8;
    function automatic logic uart_parity(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for an asynchronous input, reset value 1
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out)
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/read_uart.sv
// read_uart: UART receiver, start + 8 data bits LSB-first + optional even parity + stop
// Ports: clk, rst (sync, active-high), RxD (async, idle high),
//        data (last byte), valid (1-cycle strobe), parity_err / frame_err (qualified by valid)
// Macro READ_UART_PARITY_EN adds the parity bit between bit 7 and stop; otherwise 8N1.
module read_uart
    import uart_pkg::*;
#(
    parameter int freq = 347
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam logic [8:0] BIT_END = 9'(freq);
    localparam logic [8:0] MID = 9'(freq >> 1);
    logic       rx_s;
    rx_state_t  state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, frame_err_q, frame_err_d;
`ifdef READ_UART_PARITY_EN
    logic       par_pend_q, par_pend_d, parity_err_q, parity_err_d;
`endif
    uart_sync u_sync (.clk(clk), .rst(rst), .d(RxD), .q(rx_s));
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 9'd1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = frame_err_q;
`ifdef READ_UART_PARITY_EN
        par_pend_d   = par_pend_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (cnt_q == MID) begin
                // restarting the count here puts every later sample at mid-bit
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_END) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_s;
                idx_d          = idx_q + 3'd1;
                if (idx_q == 3'(UART_DATA_BITS - 1))
`ifdef READ_UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
            end
`ifdef READ_UART_PARITY_EN
            PARITY: if (cnt_q == BIT_END) begin
                cnt_d      = '0;
                par_pend_d = rx_s ^ uart_parity(shift_q);
                state_d    = STOP;
            end
`endif
            STOP: if (cnt_q == BIT_END) begin
                cnt_d       = '0;
                data_d      = shift_q;
                frame_err_d = ~rx_s;
                valid_d     = 1'b1;
`ifdef READ_UART_PARITY_EN
                parity_err_d = par_pend_q;
`endif
                // a low stop bit waits for the line to recover so a break yields one frame
                state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef READ_UART_PARITY_EN
            par_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef READ_UART_PARITY_EN
            par_pend_q   <= par_pend_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
`ifdef READ_UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule
